// File: rtl/mem_seq_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the memory access sequencer: FSM state encoding,
// requester indices, the default phase timeout and the priority-pick helper
// used by the arbiter.
// -----------------------------------------------------------------------------
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Requester indices; bit positions in req/wr/dbl/post_inc and all
    // one-hot outputs.
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] DMA   = 2'd2;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WAIT_W          = 8;

    // Returns the first requester of the order p0, p1, p2 whose req bit is
    // set. With no request at all the result is p2; callers qualify it with
    // |req.
    function automatic logic [1:0] pick_first(input logic [2:0] req,
                                              input logic [1:0] p0,
                                              input logic [1:0] p1,
                                              input logic [1:0] p2);
        if (req[p0])
            return p0;
        else if (req[p1])
            return p1;
        else
            return p2;
    endfunction

endpackage

// File: rtl/mem_seq_arb.sv
// -----------------------------------------------------------------------------
// mem_seq_arb
// Winner selection among the three requesters (fetch, data, dma).
//   Default build      : fixed priority dma > data > fetch, purely combinational.
//   MEM_SEQ_RR_EN      : round-robin; priority starts at the requester after the
//                        last granted one. The last-grant register resets to
//                        dma so fetch has first priority after reset.
// Ports
//   clk, reset  (MEM_SEQ_RR_EN only) clock / async active-high reset
//   load        (MEM_SEQ_RR_EN only) sequencer is in IDLE and will take the win
//   req         request vector, bit0 fetch, bit1 data, bit2 dma
//   win_idx     index of the winning requester
//   win_valid   at least one request present
// -----------------------------------------------------------------------------
module mem_seq_arb
    import mem_seq_pkg::*;
(
`ifdef MEM_SEQ_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
`endif
    input  logic [2:0] req,
    output logic [1:0] win_idx,
    output logic       win_valid
);

    assign win_valid = |req;

`ifdef MEM_SEQ_RR_EN
    logic [1:0] last;

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // in the sensitivity list, so every flop settles from the same pre-edge
    // values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= DMA;
        else if (load && win_valid)
            last <= win_idx;
    end

    // The encoding 2'b11 is unreachable; it is folded into the dma branch.
    always_comb begin
        case (last)
            FETCH:   win_idx = pick_first(req, DATA,  DMA,   FETCH);
            DATA:    win_idx = pick_first(req, DMA,   FETCH, DATA);
            default: win_idx = pick_first(req, FETCH, DATA,  DMA);
        endcase
    end
`else
    assign win_idx = pick_first(req, DMA, DATA, FETCH);
`endif

endmodule

// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq
// Memory access sequencer for three pointer-register requesters (fetch, data,
// dma). A request is accepted in IDLE, the winner's wr/dbl/post_inc are
// latched, then one (ACC0) or two (ACC0, ACC1) memory phases are run, each
// ending on mem_ready or on a wait timeout, followed by a one-cycle FIN that
// pulses done (and err / ptr_offset). All outputs are decoded from state.
// Optional feature macro: MEM_SEQ_RR_EN selects round-robin arbitration.
// Parameters
//   TIMEOUT       max mem_ready wait cycles per phase (1..255)
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   req[2:0]      access request, bit0 fetch, bit1 data, bit2 dma
//   wr[2:0]       per requester: 1 = write, 0 = read
//   dbl[2:0]      per requester: double access (pointer, then pointer+1)
//   post_inc[2:0] per requester: pulse ptr_offset after a clean completion
//   mem_ready     memory finished the current phase this cycle
//   gnt[2:0]      one-hot grant, held for the whole access
//   sel_abus      one-hot read_abus strobe (first phase)
//   sel_abusplus  one-hot read_abusplus strobe (second phase)
//   mem_rd/mem_wr memory strobes
//   ptr_offset    one-hot pointer offset strobe (in FIN)
//   done[2:0]     one-cycle completion pulse
//   err           one-cycle timeout flag, together with done
//   busy          FSM not in IDLE
// -----------------------------------------------------------------------------
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] wr,
    input  logic [2:0] dbl,
    input  logic [2:0] post_inc,
    input  logic       mem_ready,
    output logic [2:0] gnt,
    output logic [2:0] sel_abus,
    output logic [2:0] sel_abusplus,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] ptr_offset,
    output logic [2:0] done,
    output logic       err,
    output logic       busy
);

    // Count value at which the current wait cycle is the TIMEOUT-th one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              timeout_hit;
    logic              timed_out;
    logic [1:0]        g_idx;
    logic              l_wr, l_dbl, l_post;
    logic [2:0]        g_oh;
    logic [1:0]        win_idx;
    logic              win_valid;

    mem_seq_arb u_arb (
`ifdef MEM_SEQ_RR_EN
        .clk       (clk),
        .reset     (reset),
        .load      (state == IDLE),
`endif
        .req       (req),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            timed_out <= 1'b0;
            g_idx     <= FETCH;
            l_wr      <= 1'b0;
            l_dbl     <= 1'b0;
            l_post    <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state == IDLE) begin
                timed_out <= 1'b0;
                if (win_valid) begin
                    g_idx  <= win_idx;
                    l_wr   <= wr[win_idx];
                    l_dbl  <= dbl[win_idx];
                    l_post <= post_inc[win_idx];
                end
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

    // Next state and wait counter. The counter is zero whenever a phase is
    // entered, because every path into ACC0/ACC1 loads zero.
    always_comb begin
        // NOTE: every variable gets its default first so no path through the
        // case leaves it unassigned (which would infer a latch).
        state_next  = state;
        wait_next   = '0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid)
                    state_next = ACC0;
            end
            ACC0, ACC1: begin
                if (mem_ready) begin
                    state_next = (state == ACC0 && l_dbl) ? ACC1 : FIN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next  = FIN;
                    timeout_hit = 1'b1;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign g_oh = 3'b001 << g_idx;

    // Output decode. sel_abus and sel_abusplus belong to different states, so
    // they can never drive the shared address bus together.
    always_comb begin
        gnt          = 3'b000;
        sel_abus     = 3'b000;
        sel_abusplus = 3'b000;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ptr_offset   = 3'b000;
        done         = 3'b000;
        err          = 1'b0;
        case (state)
            ACC0: begin
                gnt      = g_oh;
                sel_abus = g_oh;
                mem_rd   = ~l_wr;
                mem_wr   = l_wr;
            end
            ACC1: begin
                gnt          = g_oh;
                sel_abusplus = g_oh;
                mem_rd       = ~l_wr;
                mem_wr       = l_wr;
            end
            FIN: begin
                gnt  = g_oh;
                done = g_oh;
                err  = timed_out;
                // A timed-out access leaves the pointer untouched.
                if (l_post && !timed_out)
                    ptr_offset = g_oh;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_seq
// Self-checking bench for mem_seq (TIMEOUT = 15). Completions are checked
// through a scoreboard queue; per-cycle phase behaviour and latency come from
// a table of vectors plus hand-written reset and arbitration sequences.
// Latency is counted with the cycle in which req is first driven as cycle 1.
// -----------------------------------------------------------------------------
module tb_mem_seq;

    localparam int TO = 15;

    logic       clk;
    logic       reset;
    logic [2:0] req, wr, dbl, post_inc;
    logic       mem_ready;
    logic [2:0] gnt, sel_abus, sel_abusplus, ptr_offset, done;
    logic       mem_rd, mem_wr, err, busy;

    mem_seq #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wr           (wr),
        .dbl          (dbl),
        .post_inc     (post_inc),
        .mem_ready    (mem_ready),
        .gnt          (gnt),
        .sel_abus     (sel_abus),
        .sel_abusplus (sel_abusplus),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .ptr_offset   (ptr_offset),
        .done         (done),
        .err          (err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] all_out;
    assign all_out = {gnt, sel_abus, sel_abusplus, mem_rd, mem_wr,
                      ptr_offset, done, err, busy};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Scoreboard: {done, err, ptr_offset} expected for each accepted access.
    typedef struct packed {
        logic [2:0] done;
        logic       err;
        logic [2:0] ptr;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_completion", 32'({done, err, ptr_offset}), 32'(e));
            end
        end
    end

    typedef struct {
        logic [2:0] req;      // request driven in IDLE
        logic [2:0] mid;      // req value driven once the access is running
        logic [2:0] wr;
        logic [2:0] dbl;
        logic [2:0] post;
        int         low0;     // mem_ready low cycles at start of ACC0
        int         low1;     // mem_ready low cycles at start of ACC1
        logic [2:0] exp_gnt;
        logic       exp_err;
        logic [2:0] exp_ptr;
        int         exp_lat;  // cycles from req to done, inclusive
    } vec_t;

    // Called at a negedge with the DUT in IDLE; returns at the negedge after
    // FIN, i.e. again in IDLE.
    task automatic run_vec(input string name, input vec_t v);
        int   lat;
        int   c;
        int   ph;
        int   ph_prev;
        int   low;
        logic seen;
        logic wbit;
        check({name, "_idle"}, 32'(busy), 32'd0);
        req       = v.req;
        wr        = v.wr;
        dbl       = v.dbl;
        post_inc  = v.post;
        mem_ready = 1'b1;
        sb.push_back('{done: v.exp_gnt, err: v.exp_err, ptr: v.exp_ptr});
        wbit    = |(v.wr & v.exp_gnt);
        lat     = 1;
        c       = 0;
        ph_prev = 0;
        seen    = 1'b0;
        @(negedge clk);
        req = v.mid;
        while (!seen && lat < 40) begin
            lat++;
            if (done != 3'b000) begin
                seen = 1'b1;
                check({name, "_fin"},
                      32'({gnt, sel_abus, sel_abusplus, mem_rd, mem_wr, busy}),
                      32'({v.exp_gnt, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1}));
                mem_ready = 1'b1;
            end else begin
                ph = (sel_abusplus != 3'b000) ? 2 : 1;
                if (ph != ph_prev)
                    c = 0;
                ph_prev = ph;
                check({name, "_acc"},
                      32'({gnt, sel_abus, sel_abusplus, mem_rd, mem_wr,
                           ptr_offset, err, busy}),
                      32'({v.exp_gnt,
                           (ph == 1) ? v.exp_gnt : 3'b000,
                           (ph == 2) ? v.exp_gnt : 3'b000,
                           ~wbit, wbit, 3'b000, 1'b0, 1'b1}));
                low       = (ph == 1) ? v.low0 : v.low1;
                mem_ready = (c >= low);
                c++;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    endtask

    vec_t vecs[8];
    logic [2:0] exp_seq[4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req       = 3'b000;
        wr        = 3'b000;
        dbl       = 3'b000;
        post_inc  = 3'b000;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(all_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(all_out), 32'd0);

        //          req     mid     wr      dbl     post   l0  l1  gnt    err   ptr    lat
        vecs[0] = '{3'b001, 3'b000, 3'b110, 3'b110, 3'b000, 0,  0, 3'b001, 1'b0, 3'b000, 3};
        vecs[1] = '{3'b010, 3'b101, 3'b010, 3'b010, 3'b010, 0,  0, 3'b010, 1'b0, 3'b010, 4};
        vecs[2] = '{3'b100, 3'b011, 3'b011, 3'b100, 3'b011, 0,  0, 3'b100, 1'b0, 3'b000, 4};
        vecs[3] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3,  0, 3'b001, 1'b0, 3'b001, 6};
        vecs[4] = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 1,  2, 3'b010, 1'b0, 3'b010, 7};
        vecs[5] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b100, TO, 0, 3'b100, 1'b1, 3'b000, 17};
        vecs[6] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 0, TO, 3'b001, 1'b1, 3'b000, 18};
        vecs[7] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 14, 0, 3'b100, 1'b0, 3'b100, 17};

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a double access: outputs drop at once and
        // the aborted access never completes.
        req       = 3'b001;
        wr        = 3'b000;
        dbl       = 3'b001;
        post_inc  = 3'b001;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rst_acc0", 32'({sel_abus, mem_rd, busy}), 32'({3'b001, 1'b1, 1'b1}));
        @(negedge clk);
        check("rst_acc1", 32'({sel_abus, sel_abusplus, busy}),
              32'({3'b000, 3'b001, 1'b1}));
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 32'(all_out), 32'd0);
        req = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_completion", 32'({done, err, ptr_offset, busy}), 32'd0);
        end

        // Permanent request from all three requesters, back to back.
`ifdef MEM_SEQ_RR_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100};
`endif
        for (int k = 0; k < 4; k++)
            run_vec($sformatf("arb%0d", k),
                    '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 0, 0,
                      exp_seq[k], 1'b0, 3'b000, 3});

        req = 3'b000;
        repeat (3) @(negedge clk);
        check("final_idle", 32'(all_out), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
